// File: rtl/alu_mc.sv
// Handshaked ALU: 13 single-cycle ops plus iterative MUL/DIVU/REMU, one op in flight.
// Define ALU_MC_MULDIV_EN to build the multi-cycle MUL/DIV datapath; otherwise ops D-F return 0.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SLTU = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SLLS = 4'hA;
  localparam logic [3:0] OP_SGEU = 4'hB;
  localparam logic [3:0] OP_SGE  = 4'hC;
`ifdef ALU_MC_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_DIVU = 4'hE;
  localparam logic [3:0] OP_REMU = 4'hF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] o_q;

  // Single-cycle ops; anything not listed (including D-F) yields zero.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [SHW-1:0] sh;
    sh = y[SHW-1:0];
    case (op)
      OP_ADD:           alu_op = x + y;
      OP_SUB:           alu_op = x - y;
      OP_OR:            alu_op = x | y;
      OP_XOR:           alu_op = x ^ y;
      OP_AND:           alu_op = x & y;
      OP_SLTU:          alu_op = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLT:           alu_op = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SRL:           alu_op = x >> sh;
      OP_SRA:           alu_op = $signed(x) >>> sh;
      OP_SLL, OP_SLLS:  alu_op = x << sh;
      OP_SGEU:          alu_op = {{(WIDTH-1){1'b0}}, (x >= y)};
      OP_SGE:           alu_op = {{(WIDTH-1){1'b0}}, ($signed(x) >= $signed(y))};
      default:          alu_op = '0;
    endcase
  endfunction

`ifdef ALU_MC_MULDIV_EN
  // opa: multiplicand / divisor, opb: multiplier / dividend-then-quotient,
  // acc: partial product / partial remainder.
  logic [WIDTH-1:0] opa, opb, acc;
  logic [SHW-1:0]   cnt;
  logic             is_rem;
  logic [WIDTH-1:0] mul_acc_nxt, div_rem_nxt, div_q_nxt;
  logic [WIDTH:0]   rem_sh, trial;
  logic             last;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    mul_acc_nxt = acc + (opb[0] ? opa : '0);
    rem_sh      = {acc, opb[WIDTH-1]};
    trial       = rem_sh - {1'b0, opa};
    if (trial[WIDTH]) begin
      div_rem_nxt = rem_sh[WIDTH-1:0];
      div_q_nxt   = {opb[WIDTH-2:0], 1'b0};
    end else begin
      div_rem_nxt = trial[WIDTH-1:0];
      div_q_nxt   = {opb[WIDTH-2:0], 1'b1};
    end
    last = (cnt == SHW'(WIDTH-1));
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      o_q   <= '0;
`ifdef ALU_MC_MULDIV_EN
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      is_rem <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
            is_rem <= (operation == OP_REMU);
            acc    <= '0;
            cnt    <= '0;
            case (operation)
              OP_MUL: begin
                opa   <= X;
                opb   <= Y;
                state <= MUL;
              end
              OP_DIVU, OP_REMU: begin
                if (Y == '0) begin
                  o_q   <= (operation == OP_REMU) ? X : '1;
                  state <= DONE;
                end else begin
                  opa   <= Y;
                  opb   <= X;
                  state <= DIV;
                end
              end
              default: begin
                o_q   <= alu_op(operation, X, Y);
                state <= DONE;
              end
            endcase
`else
            o_q   <= alu_op(operation, X, Y);
            state <= DONE;
`endif
          end
        end
`ifdef ALU_MC_MULDIV_EN
        MUL: begin
          acc <= mul_acc_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + SHW'(1);
          if (last) begin
            o_q   <= mul_acc_nxt;
            state <= DONE;
          end
        end
        DIV: begin
          acc <= div_rem_nxt;
          opb <= div_q_nxt;
          cnt <= cnt + SHW'(1);
          if (last) begin
            o_q   <= is_rem ? div_rem_nxt : div_q_nxt;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O         = o_q;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
`ifdef ALU_MC_MULDIV_EN
  assign busy      = (state == MUL) || (state == DIV);
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Keeps the 13 existing single-cycle operations, with width generalised to WIDTH. Adds iterative multi-cycle MUL/DIVU/REMU.
- Sits between the decode/execute stage and writeback.
- One operation in flight at a time. Result is registered and held until the consumer accepts it.

Parameters:
- WIDTH, 32, data path width in bits; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- operation  input  4  operation code, see Behaviour
- X  input  WIDTH  operand 1
- Y  input  WIDTH  operand 2
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- O  output  WIDTH  result
- busy  output  1  unit in a multi-cycle state

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, O=0, busy=0. Counters and accumulators are cleared.
- Reset mid-operation: any in-progress MUL/DIV is abandoned and the pending result is discarded. The cycle after reset deasserts, the unit is in IDLE.
- Operation codes:
  - 0 ADD, 1 SUB, 2 OR, 3 XOR, 4 AND.
  - 5 SLTU, 6 SLT (result 0 or 1, zero-extended).
  - 7 SRL, 8 SRA, 9 SLL, A SLL (signed left shift is identical to SLL).
  - B SGEU, C SGE (0 or 1).
  - D MUL (low WIDTH bits of the product), E DIVU, F REMU.
- Shift amount: Y[SHW-1:0]; upper bits of Y are ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- Handshake: a request is accepted when in_valid && in_ready. Operands and opcode are latched on acceptance; input changes afterwards have no effect.
- in_ready = (state==IDLE).
- State machine:
  - IDLE: on accept of ops 0-C, compute and register O, then go to DONE. On D go to MUL; on E/F go to DIV.
  - MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles, then DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then DONE.
  - DIV with Y==0: skip iteration and go to DONE in 1 cycle. DIVU result = all ones; REMU result = X.
  - DONE: out_valid=1, O held stable. Go to IDLE when out_ready=1; remain in DONE otherwise.
- Latency from the accept cycle N:
  - ops 0-C: out_valid at N+1.
  - MUL/DIV/REM: out_valid at N+WIDTH+1.
  - divide by zero: out_valid at N+1.
- Throughput: at most one accept every 2 cycles, since in_ready is low in DONE.
- busy=1 in the MUL and DIV states only.
- out_valid and out_ready arriving in the same cycle as a new in_valid: the result completes first, and the new request is accepted only in the following IDLE cycle.

Optional Feature:
- Macro: ALU_MC_MULDIV_EN.
- Defined: MUL/DIVU/REMU are implemented as above.
- Undefined: the MUL and DIV states and their datapath are not built. Ops D/E/F behave as single-cycle ops returning O=0 (out_valid at N+1), and busy is tied to 0.

Test Plan:
- After reset, check in_ready=1, out_valid=0, O=0. Send ADD X=0xFFFFFFFF, Y=2 -> out_valid at N+1 with O=0x00000001, held while out_ready=0 for 3 cycles.
- SRA X=0x80000000, Y=0x00000024 (shamt 4) -> O=0xF8000000. SLT X=0xFFFFFFFF, Y=1 -> O=1. SLTU with the same operands -> O=0.
- MUL X=0x00010003, Y=0x00020005 -> O=0x000B000F, with out_valid exactly at N+33 and busy high for 32 cycles.
- DIVU X=100, Y=7 -> O=14. REMU X=100, Y=7 -> O=2. DIVU X=5, Y=0 -> O=0xFFFFFFFF at N+1. REMU X=5, Y=0 -> O=5.
- Assert reset at cycle 10 of a DIVU, then issue ADD 3+4 -> no stale result appears, O=7 at N+1.
- Run with WIDTH=16 and the macro undefined: MUL 3*4 -> O=0 at N+1, busy stays 0. SLL X=1, Y=0x0013 (shamt 3) -> O=8.
